sp_row_requester: RTL and testbench
===================================

// Module: sp_row_requester
// PURPOSE
//  GEMM-side initiator for one scratchpad bank: turns a single load command into NUM_ROWS row-read
//  requests pushed into the bank's rFIFO, then pops the returned rows from the bank's gemmFIFO and
//  streams them in order to the systolic-array feeder over a valid/ready port.
//  Sits between the GEMM control FSM and the scratchpad bank (drives the bank's sp modport inputs).
// PARAMETERS (widths WORD_W, MAT_S_W, ROW_S_W, BITS_PER_ROW come from types_pkg)
//  NUM_ROWS    4   rows per matrix load; row_id runs 0..NUM_ROWS-1
//  MAX_OUTST   4   max requests in flight (issued, not yet popped from gemmFIFO)
//  ROW_STRIDE  8   dram_addr increment per row, in address units
// PORTS
//  CLK             in   1                            clock
//  RST             in   1                            async reset, active-high
//  start           in   1                            1-cycle load command; ignored unless IDLE
//  start_type      in   2                            request type, copied into every request
//  start_mat       in   MAT_S_W                      matrix id
//  start_addr      in   WORD_W                       DRAM address of row 0
//  busy            out  1                            high whenever state != IDLE
//  done            out  1                            1-cycle pulse, load finished
//  rFIFO_WEN       out  1                            push request into bank read-request FIFO
//  rFIFO_wdata     out  WORD_W+MAT_S_W+ROW_S_W+2     {type[1:0], dram_addr, mat_id, row_id}
//  rFIFO_full      in   1                            bank request FIFO full
//  gemmFIFO_REN    out  1                            pop returned row
//  gemmFIFO_rdata  in   BITS_PER_ROW+MAT_S_W+ROW_S_W+2  {type[1:0], row_data, mat_id, row_id}
//  gemmFIFO_empty  in   1                            no returned row available
//  row_valid       out  1                            output row valid
//  row_ready       in   1                            downstream accepts row
//  row_data        out  BITS_PER_ROW                 row payload
//  row_id          out  ROW_S_W                      row index of row_data
//  row_last        out  1                            high with row NUM_ROWS-1
//  id_err          out  1                            sticky id-mismatch flag (ROW_CHECK_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; busy, done, rFIFO_WEN, gemmFIFO_REN, row_valid, row_last,
//   id_err = 0; row_data, row_id = 0. Reset mid-load drops everything; no further FIFO traffic.
//  FSM: IDLE -start-> ISSUE (latch type/mat/addr, issue_cnt=rx_cnt=outst=0)
//   ISSUE -last request pushed-> DRAIN
//   DRAIN -rx_cnt==NUM_ROWS && row accepted (or !row_valid)-> DONE
//   DONE -> IDLE (done=1 this cycle only). start in DONE is ignored.
//  Issue (combinational from registered state): rFIFO_WEN = ISSUE && !rFIFO_full && outst<MAX_OUTST.
//   wdata = {type, base+issue_cnt*ROW_STRIDE (mod 2^WORD_W, wraps silently), mat, issue_cnt}.
//   Push increments issue_cnt. rFIFO_full=1 -> hold, no WEN, no counter change.
//  Return: gemmFIFO is show-ahead (rdata valid while !empty). gemmFIFO_REN = (ISSUE||DRAIN) &&
//   !gemmFIFO_empty && (!row_valid || row_ready). Next edge: row_valid=1, row_data/row_id loaded
//   from rdata, row_last=(rx_cnt==NUM_ROWS-1), rx_cnt++. Pop latency 1 cycle; full throughput
//   1 row/cycle when row_ready held high.
//  row_valid held with stable data until row_ready; accepted with no new pop -> row_valid=0.
//  outst: +1 on push, -1 on pop, unchanged on simultaneous push+pop; never exceeds MAX_OUTST.
//  Pops beyond NUM_ROWS never occur (REN also gated by rx_cnt<NUM_ROWS).
// CONFIGURATION
//  SP_ROW_CHECK_EN defined: on each pop compare rdata mat_id/row_id with latched mat/rx_cnt;
//   mismatch sets id_err (sticky until RST); data still forwarded. Undefined: id_err tied 0, no
//   comparator logic.
// TESTING
//  1 start mat=2 addr=0x100 type=1, rFIFO_full=0 -> 4 consecutive WEN, addrs 0x100,0x108,0x110,
//    0x118, row_id 0..3; bank model returns rows -> 4 rows out in order, row_last on id 3, done x1.
//  2 rFIFO_full=1 for cycles 2-5 of ISSUE -> WEN low exactly those cycles, no duplicate/skipped id.
//  3 MAX_OUTST=2, bank delays returns 10 cycles -> at most 2 pushes before first pop; outst<=2.
//  4 row_ready=0 for 6 cycles with gemmFIFO nonempty -> row_valid/row_data stable, REN=0 throughout.
//  5 addr=0xFFFFFFF8 (WORD_W=32) -> row1 addr 0x00000000 (wrap); RST asserted mid-DRAIN -> all
//    outputs 0 next cycle, state IDLE, new start works.
//  6 SP_ROW_CHECK_EN: return row_id 2 where 1 expected -> id_err=1, stays 1, load still completes.

Source files
------------

// File: rtl/sp_row_requester.sv
// sp_row_requester: GEMM-side initiator for one scratchpad bank.
// A single load command becomes NUM_ROWS row-read requests pushed into the
// bank rFIFO. The returned rows are popped from the show-ahead gemmFIFO and
// streamed in order over a valid/ready port.
// Optional feature: define SP_ROW_CHECK_EN to compare the mat/row id of each
// returned row against the expected values. A mismatch sets the sticky id_err.

package types_pkg;
  localparam int WORD_W       = 32;
  localparam int MAT_S_W      = 4;
  localparam int ROW_S_W      = 4;
  localparam int BITS_PER_ROW = 64;
endpackage

module sp_row_requester
  import types_pkg::*;
#(
  parameter int NUM_ROWS   = 4,
  parameter int MAX_OUTST  = 4,
  parameter int ROW_STRIDE = 8
) (
  input  logic                                     CLK,
  input  logic                                     RST,
  input  logic                                     start,
  input  logic [1:0]                               start_type,
  input  logic [MAT_S_W-1:0]                       start_mat,
  input  logic [WORD_W-1:0]                        start_addr,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     rFIFO_WEN,
  output logic [WORD_W+MAT_S_W+ROW_S_W+1:0]        rFIFO_wdata,
  input  logic                                     rFIFO_full,
  output logic                                     gemmFIFO_REN,
  input  logic [BITS_PER_ROW+MAT_S_W+ROW_S_W+1:0]  gemmFIFO_rdata,
  input  logic                                     gemmFIFO_empty,
  output logic                                     row_valid,
  input  logic                                     row_ready,
  output logic [BITS_PER_ROW-1:0]                  row_data,
  output logic [ROW_S_W-1:0]                       row_id,
  output logic                                     row_last,
  output logic                                     id_err
);
  localparam int CNT_W = $clog2(NUM_ROWS + 1);
  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam int RD_W  = BITS_PER_ROW + MAT_S_W + ROW_S_W + 2;

  localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(NUM_ROWS - 1);
  localparam logic [CNT_W-1:0]  ALL_ROWS = CNT_W'(NUM_ROWS);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUTST);
  localparam logic [OUT_W-1:0]  OUT_ONE  = OUT_W'(1);
  localparam logic [WORD_W-1:0] STRIDE   = WORD_W'(ROW_STRIDE);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t stateReg, stateNext;

  logic [1:0]        typeReg;
  logic [MAT_S_W-1:0] matReg;
  // Address of the next request; advanced by ROW_STRIDE per push and wraps
  // modulo 2^WORD_W, which equals base + issueCnt*ROW_STRIDE.
  logic [WORD_W-1:0] addrReg;
  logic [CNT_W-1:0]  issueCntReg;
  logic [CNT_W-1:0]  rxCntReg;
  logic [OUT_W-1:0]  outstReg;

  logic                    rowValidReg;
  logic [BITS_PER_ROW-1:0] rowDataReg;
  logic [ROW_S_W-1:0]      rowIdReg;
  logic                    rowLastReg;

  // Field split of the returned row {type, data, mat, row}
  logic [1:0]              rdType;
  logic [BITS_PER_ROW-1:0] rdData;
  logic [MAT_S_W-1:0]      rdMat;
  logic [ROW_S_W-1:0]      rdRowId;

  assign rdRowId = gemmFIFO_rdata[ROW_S_W-1:0];
  assign rdMat   = gemmFIFO_rdata[ROW_S_W +: MAT_S_W];
  assign rdData  = gemmFIFO_rdata[ROW_S_W+MAT_S_W +: BITS_PER_ROW];
  assign rdType  = gemmFIFO_rdata[RD_W-1 -: 2];

  // A pop may happen only when a row is waiting and the output slot is free
  // or is being freed this cycle. Pops never exceed NUM_ROWS.
  logic canPop;
  assign canPop = !gemmFIFO_empty && (!rowValidReg || row_ready) && (rxCntReg < ALL_ROWS);

  assign rFIFO_wdata = {typeReg, addrReg, matReg, ROW_S_W'(issueCntReg)};

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) stateReg <= IDLE;
    else     stateReg <= stateNext;
  end

  // Next state, FIFO strobes and status outputs
  always_comb begin
    stateNext    = stateReg;
    rFIFO_WEN    = 1'b0;
    gemmFIFO_REN = 1'b0;
    busy         = (stateReg != IDLE);
    done         = 1'b0;
    case (stateReg)
      IDLE: begin
        if (start) stateNext = ISSUE;
      end
      ISSUE: begin
        rFIFO_WEN    = !rFIFO_full && (outstReg < OUT_MAX);
        gemmFIFO_REN = canPop;
        if (rFIFO_WEN && (issueCntReg == LAST_ROW)) stateNext = DRAIN;
      end
      DRAIN: begin
        gemmFIFO_REN = canPop;
        if ((rxCntReg == ALL_ROWS) && (!rowValidReg || row_ready)) stateNext = DONE;
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Latch the load command and track issued, received and in-flight rows
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      typeReg     <= '0;
      matReg      <= '0;
      addrReg     <= '0;
      issueCntReg <= '0;
      rxCntReg    <= '0;
      outstReg    <= '0;
    end else if (stateReg == IDLE) begin
      if (start) begin
        typeReg     <= start_type;
        matReg      <= start_mat;
        addrReg     <= start_addr;
        issueCntReg <= '0;
        rxCntReg    <= '0;
        outstReg    <= '0;
      end
    end else begin
      if (rFIFO_WEN) begin
        issueCntReg <= issueCntReg + CNT_ONE;
        addrReg     <= addrReg + STRIDE;
      end
      if (gemmFIFO_REN) rxCntReg <= rxCntReg + CNT_ONE;
      case ({rFIFO_WEN, gemmFIFO_REN})
        2'b10:   outstReg <= outstReg + OUT_ONE;
        2'b01:   outstReg <= outstReg - OUT_ONE;
        default: outstReg <= outstReg;
      endcase
    end
  end

  // Output row slot: load on pop, hold until accepted, then empty
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rowValidReg <= 1'b0;
      rowDataReg  <= '0;
      rowIdReg    <= '0;
      rowLastReg  <= 1'b0;
    end else if (gemmFIFO_REN) begin
      rowValidReg <= 1'b1;
      rowDataReg  <= rdData;
      rowIdReg    <= rdRowId;
      rowLastReg  <= (rxCntReg == LAST_ROW);
    end else if (row_ready) begin
      rowValidReg <= 1'b0;
    end
  end

  assign row_valid = rowValidReg;
  assign row_data  = rowDataReg;
  assign row_id    = rowIdReg;
  assign row_last  = rowLastReg;

`ifdef SP_ROW_CHECK_EN
  logic idMismatch;
  logic idErrReg;
  logic unusedBits;

  assign idMismatch = (rdMat != matReg) || (rdRowId != ROW_S_W'(rxCntReg));

  // Sticky flag for a returned row whose ids do not match the expected ones
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              idErrReg <= 1'b0;
    else if (gemmFIFO_REN && idMismatch)  idErrReg <= 1'b1;
  end

  assign id_err     = idErrReg;
  assign unusedBits = ^rdType;
`else
  logic unusedBits;

  assign id_err     = 1'b0;
  assign unusedBits = ^{rdType, rdMat};
`endif

endmodule

// File: tb/tb_sp_row_requester.sv
`timescale 1ns/1ps
// Bench for sp_row_requester. It runs a table of directed loads, then
// randomized loads, a corrupted returned row id, and a reset in the middle of
// a load. A queue models the bank. The expected requests and rows are computed
// with plain arithmetic: row i sits at base + i*stride, and row data is a
// fixed function of the row address.
module tb_sp_row_requester;
  import types_pkg::*;

  localparam int NUM    = 4;
  localparam int MAXO   = 2;
  localparam int STRIDE = 8;
  localparam int WD_W   = WORD_W + MAT_S_W + ROW_S_W + 2;
  localparam int RD_W   = BITS_PER_ROW + MAT_S_W + ROW_S_W + 2;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic                    start = 1'b0;
  logic [1:0]              start_type = '0;
  logic [MAT_S_W-1:0]      start_mat = '0;
  logic [WORD_W-1:0]       start_addr = '0;
  logic                    busy, done;
  logic                    rFIFO_WEN;
  logic [WD_W-1:0]         rFIFO_wdata;
  logic                    rFIFO_full = 1'b0;
  logic                    gemmFIFO_REN;
  logic [RD_W-1:0]         gemmFIFO_rdata = '0;
  logic                    gemmFIFO_empty = 1'b1;
  logic                    row_valid;
  logic                    row_ready = 1'b1;
  logic [BITS_PER_ROW-1:0] row_data;
  logic [ROW_S_W-1:0]      row_id;
  logic                    row_last;
  logic                    id_err;

  always #5 CLK = ~CLK;

  sp_row_requester #(.NUM_ROWS(NUM), .MAX_OUTST(MAXO), .ROW_STRIDE(STRIDE)) dut (
    .CLK(CLK), .RST(RST), .start(start), .start_type(start_type),
    .start_mat(start_mat), .start_addr(start_addr), .busy(busy), .done(done),
    .rFIFO_WEN(rFIFO_WEN), .rFIFO_wdata(rFIFO_wdata), .rFIFO_full(rFIFO_full),
    .gemmFIFO_REN(gemmFIFO_REN), .gemmFIFO_rdata(gemmFIFO_rdata),
    .gemmFIFO_empty(gemmFIFO_empty), .row_valid(row_valid), .row_ready(row_ready),
    .row_data(row_data), .row_id(row_id), .row_last(row_last), .id_err(id_err)
  );

  typedef struct {
    logic [WORD_W-1:0]  addr;
    logic [MAT_S_W-1:0] mat;
    logic [1:0]         typ;
    logic [15:0]        fullMask;   // rFIFO_full per cycle since start
    logic [31:0]        readyMask;  // row_ready per cycle since start
    int                 lat;        // bank return latency in cycles
    bit                 midStart;   // pulse a stray start during ISSUE
    logic [WORD_W-1:0]  expRow1;    // address expected in the second request
  } vec_t;

  typedef struct {
    int                      rdy;
    logic [1:0]              typ;
    logic [BITS_PER_ROW-1:0] data;
    logic [MAT_S_W-1:0]      mat;
    logic [ROW_S_W-1:0]      id;
  } bank_t;

  vec_t  vecs[5];
  vec_t  curV;
  bank_t bankQ[$];

  int errors = 0, checks = 0;
  int cyc = 0, k = 0, pushes = 0, pops = 0, accepts = 0, doneCnt = 0;
  int corruptIdx = -1;
  bit active = 1'b0, idErrExp = 1'b0;
  logic [WORD_W-1:0] row1Addr;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BITS_PER_ROW-1:0] rowFn(input logic [WORD_W-1:0] a);
    return {a ^ 32'hA5A5_5A5A, a + 32'h1357_2468};
  endfunction

  // Address of row i of the current load, modulo 2^WORD_W
  function automatic logic [WORD_W-1:0] rowAddr(input int i);
    return curV.addr + WORD_W'(i * STRIDE);
  endfunction

  function automatic logic [ROW_S_W-1:0] expOutId(input int i);
    return (i == corruptIdx) ? ROW_S_W'(2) : ROW_S_W'(i);
  endfunction

  task automatic checkAllZero(input string name);
    check({name, ".busy"}, busy, 0);
    check({name, ".done"}, done, 0);
    check({name, ".rFIFO_WEN"}, rFIFO_WEN, 0);
    check({name, ".gemmFIFO_REN"}, gemmFIFO_REN, 0);
    check({name, ".row_valid"}, row_valid, 0);
    check({name, ".row_last"}, row_last, 0);
    check({name, ".id_err"}, id_err, 0);
    check({name, ".row_data"}, row_data, 0);
    check({name, ".row_id"}, row_id, 0);
  endtask

  // One clock cycle. It is entered and left at a negedge.
  task automatic step(input bit startNow);
    bit expWen, expRen, expValid, expDone, wen, ren, acc;
    logic [WD_W-1:0] wdataNow;
    bank_t e;
    rFIFO_full = (active && k < 16) ? curV.fullMask[k] : 1'b0;
    row_ready  = (active && k < 32) ? curV.readyMask[k] : 1'b1;
    if (bankQ.size() > 0 && bankQ[0].rdy <= cyc) begin
      gemmFIFO_empty = 1'b0;
      gemmFIFO_rdata = {bankQ[0].typ, bankQ[0].data, bankQ[0].mat, bankQ[0].id};
    end else begin
      gemmFIFO_empty = 1'b1;
      gemmFIFO_rdata = RD_W'({$urandom, $urandom, $urandom});
    end
    if (curV.midStart && active && k == 2) begin
      start      = 1'b1;
      start_addr = ~curV.addr;
      start_mat  = ~curV.mat;
    end
    #1;
    expValid = (pops > accepts);
    expWen   = active && (pushes < NUM) && !rFIFO_full && ((pushes - pops) < MAXO);
    expRen   = active && !gemmFIFO_empty && (!expValid || row_ready) && (pops < NUM);
    expDone  = active && (accepts == NUM);
    check("rFIFO_WEN", rFIFO_WEN, expWen);
    check("gemmFIFO_REN", gemmFIFO_REN, expRen);
    check("row_valid", row_valid, expValid);
    check("busy", busy, active);
    check("done", done, expDone);
    check("id_err", id_err, idErrExp);
    if (expValid) begin
      check("row_data", row_data, rowFn(rowAddr(accepts)));
      check("row_id", row_id, expOutId(accepts));
      check("row_last", row_last, accepts == NUM - 1);
    end
    wen = rFIFO_WEN;
    ren = gemmFIFO_REN;
    acc = expValid && row_ready;
    wdataNow = rFIFO_wdata;
    if (wen && expWen) begin
      check("rFIFO_wdata", wdataNow, {curV.typ, rowAddr(pushes), curV.mat, ROW_S_W'(pushes)});
      if (pushes == 1) row1Addr = wdataNow[ROW_S_W+MAT_S_W +: WORD_W];
    end
    if (done) doneCnt++;
    if (expDone) start = 1'b1;  // start while in DONE must be ignored
    @(posedge CLK);
    if (ren && bankQ.size() > 0) begin
`ifdef SP_ROW_CHECK_EN
      if (bankQ[0].id != ROW_S_W'(pops) || bankQ[0].mat != curV.mat) idErrExp = 1'b1;
`endif
      e = bankQ.pop_front();
      pops++;
    end
    if (wen) begin
      e.rdy  = cyc + curV.lat;
      e.typ  = wdataNow[WD_W-1 -: 2];
      e.data = rowFn(wdataNow[ROW_S_W+MAT_S_W +: WORD_W]);
      e.mat  = wdataNow[ROW_S_W +: MAT_S_W];
      e.id   = (pushes == corruptIdx) ? ROW_S_W'(2) : wdataNow[ROW_S_W-1:0];
      bankQ.push_back(e);
      pushes++;
    end
    if (acc) accepts++;
    if (expDone) active = 1'b0;
    if (startNow) begin
      active = 1'b1; pushes = 0; pops = 0; accepts = 0; doneCnt = 0; k = 0;
    end else begin
      k++;
    end
    cyc++;
    @(negedge CLK);
    start      = 1'b0;
    start_addr = curV.addr;
    start_mat  = curV.mat;
  endtask

  task automatic runLoad(input vec_t v);
    int n;
    curV       = v;
    start_type = v.typ;
    start_mat  = v.mat;
    start_addr = v.addr;
    start      = 1'b1;
    row1Addr   = '0;
    step(1'b1);
    n = 0;
    while (active && n < 300) begin
      step(1'b0);
      n++;
    end
    if (active) begin
      checks++;
      errors++;
      $display("FAIL load_timeout: load still open after %0d cycles, required done", n);
      active = 1'b0; pushes = 0; pops = 0; accepts = 0;
      bankQ.delete();
    end
    check("done_count", doneCnt, 1);
    check("row1_addr", row1Addr, v.expRow1);
    step(1'b0);  // idle cycle: no traffic, busy low
  endtask

  initial begin
    int n;
    vec_t v;
    vecs[0] = '{addr:32'h0000_0100, mat:4'd2, typ:2'd1, fullMask:16'h0000,
                readyMask:32'hFFFF_FFFF, lat:1, midStart:1'b0, expRow1:32'h0000_0108};
    vecs[1] = '{addr:32'h0000_2000, mat:4'd5, typ:2'd2, fullMask:16'h003C,
                readyMask:32'hFFFF_FFFF, lat:2, midStart:1'b0, expRow1:32'h0000_2008};
    vecs[2] = '{addr:32'h0000_0040, mat:4'd1, typ:2'd3, fullMask:16'h0000,
                readyMask:32'hFFFF_FFFF, lat:10, midStart:1'b0, expRow1:32'h0000_0048};
    vecs[3] = '{addr:32'h0000_0800, mat:4'd7, typ:2'd0, fullMask:16'h0000,
                readyMask:32'hFFFF_FE07, lat:1, midStart:1'b1, expRow1:32'h0000_0808};
    vecs[4] = '{addr:32'hFFFF_FFF8, mat:4'd3, typ:2'd1, fullMask:16'h0000,
                readyMask:32'hFFFF_FFFF, lat:1, midStart:1'b0, expRow1:32'h0000_0000};
    curV = vecs[0];

    repeat (2) @(negedge CLK);
    #1 checkAllZero("reset");
    RST = 1'b0;
    @(negedge CLK);

    for (int i = 0; i < 5; i++) runLoad(vecs[i]);

    for (int i = 0; i < 25; i++) begin
      v.addr      = $urandom;
      v.mat       = MAT_S_W'($urandom);
      v.typ       = 2'($urandom);
      v.fullMask  = 16'($urandom);
      v.readyMask = $urandom;
      v.lat       = int'($urandom_range(1, 6));
      v.midStart  = 1'($urandom);
      v.expRow1   = v.addr + WORD_W'(STRIDE);
      runLoad(v);
    end

    // Returned row 1 carries row id 2: the data is still forwarded and the
    // load completes. With the checker built in, id_err rises and stays set.
    corruptIdx = 1;
    runLoad(vecs[0]);
    corruptIdx = -1;
    runLoad(vecs[1]);

    // Reset in the middle of DRAIN with rows still in flight
    curV       = vecs[0];
    start_type = curV.typ;
    start_mat  = curV.mat;
    start_addr = curV.addr;
    start      = 1'b1;
    step(1'b1);
    n = 0;
    while (!(pushes == NUM && accepts >= 1) && n < 50) begin
      step(1'b0);
      n++;
    end
    check("reached_drain", (pushes == NUM && accepts >= 1), 1);
    #2 RST = 1'b1;
    #1 checkAllZero("rst_mid");
    active = 1'b0; pushes = 0; pops = 0; accepts = 0; idErrExp = 1'b0;
    gemmFIFO_empty = 1'b0;
    row_ready      = 1'b1;
    @(negedge CLK);
    #1 checkAllZero("rst_hold");
    RST = 1'b0;
    @(negedge CLK);
    // Stale rows remain in the bank queue; nothing may be popped or pushed
    repeat (3) step(1'b0);
    bankQ.delete();
    runLoad(vecs[4]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
